ysyx_25010008_prefetch_ifu: RTL and testbench
=============================================

YSYX_25010008_PREFETCH_IFU -- requirements
Module: ysyx_25010008_prefetch_ifu

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 4, meaning instruction queue entries; legal values are powers of two from 2 to 16.
REQ-003 SHALL have parameter CW, default $clog2(DEPTH)+1, meaning the width of the occupancy and outstanding counters.
REQ-004 Port list, one clock, async active-low reset:
  clk          in   1   clock, rising edge
  rst          in   1   asynchronous, active-low reset
  pvalid       out  1   fetch request valid
  pready       in   1   memory accepts request
  paddr        out  32  fetch address
  rvalid       in   1   read response valid
  rready       out  1   response accept
  rdata        in   32  response data
  rresp        in   1   1 = access error
  ivalid       out  1   instruction valid to decode
  iready       in   1   decode accepts instruction
  inst         out  32  instruction word
  ipc          out  32  PC of inst
  ierr         out  1   inst is from an errored fetch
  redirect     in   1   flush and restart fetch
  redirect_pc  in   32  new fetch PC (bits [1:0] SHALL be ignored and treated as 0)

Function
REQ-005 State: fetch_pc, resp_pc, out_cnt (issued, not yet answered), drop_cnt, run, halt, and a circular queue of DEPTH {inst, pc, err} entries with rd_ptr, wr_ptr and count.
REQ-006 run SHALL be 0 in reset and SHALL be set at the first rising edge after rst deasserts.
REQ-007 pvalid SHALL equal run & !halt & !redirect & (count + out_cnt < DEPTH), combinationally.
REQ-008 paddr SHALL equal fetch_pc.
REQ-009 On pvalid & pready: fetch_pc += 4 with 32-bit wrap, and out_cnt += 1.
REQ-010 rready SHALL equal run, so responses are never back-pressured; the credit rule in REQ-007 guarantees queue space.
REQ-011 Responses arrive in request order; each rvalid & rready SHALL decrement out_cnt.
REQ-012 For each accepted response:
  - drop_cnt > 0: discard it and decrement drop_cnt.
  - else if halt = 1: discard it.
  - else: push {rdata, resp_pc, rresp}, then resp_pc += 4.
REQ-013 A pushed entry with rresp = 1 SHALL set halt; issuing stops until redirect.
REQ-014 ivalid SHALL equal count != 0, and inst/ipc/ierr SHALL show the entry at rd_ptr.
REQ-015 On ivalid & iready, rd_ptr SHALL advance; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-016 Decode-to-output latency: an instruction pushed at edge N SHALL appear on ivalid from cycle N (registered queue, no bypass); minimum fetch-to-ivalid is 1 cycle after the response handshake.
REQ-017 On redirect (priority over every other update in that cycle):
  - count, rd_ptr and wr_ptr SHALL be cleared.
  - fetch_pc and resp_pc SHALL be set to redirect_pc.
  - halt SHALL be cleared.
  - drop_cnt SHALL be set to out_cnt minus 1 if a response is accepted that cycle (that response is discarded), else to out_cnt.
  - out_cnt SHALL update per REQ-011.
  - An output handshake in the redirect cycle counts as consumed.
REQ-018 No request SHALL issue in a redirect cycle (REQ-007); the first request to redirect_pc SHALL issue the following cycle if credits allow.
REQ-019 Pointers SHALL wrap modulo DEPTH; count and out_cnt SHALL never exceed DEPTH.
REQ-020 rvalid with out_cnt = 0 is a protocol violation; the response SHALL be ignored and out_cnt SHALL not underflow.

Reset
REQ-021 While rst = 0:
  - fetch_pc and resp_pc = RESET_PC.
  - out_cnt, drop_cnt, count, pointers, halt and run = 0.
  - pvalid, rready and ivalid = 0.
  - paddr = RESET_PC.
  - inst, ipc and ierr = 0.
REQ-022 Reset assertion mid-transaction SHALL immediately clear all state; responses to pre-reset requests are the memory's responsibility and SHALL NOT be tracked.

Verification
REQ-023 Reset release, pready = 1, fixed-latency memory returning 0x13 at 2 cycles, iready = 1 -> paddr sequence 0x80000000, 0x80000004, ...; ipc matches; at most DEPTH requests outstanding.
REQ-024 iready = 0 with DEPTH = 4 -> exactly 4 requests issue, count = 4, pvalid = 0; then iready = 1 for 1 cycle -> exactly one new request issues.
REQ-025 Redirect to 0x80001000 with 3 requests outstanding -> those 3 responses are discarded; the next ivalid has ipc = 0x80001000; no stale instruction appears.
REQ-026 rresp = 1 on the response for 0x80000008 -> that entry has ierr = 1; pvalid stays 0; later in-flight responses are discarded; redirect resumes fetch.
REQ-027 Redirect in the same cycle as a response and an output handshake -> response dropped, drop_cnt = out_cnt - 1, count = 0 next cycle.
REQ-028 rst asserted asynchronously mid-burst -> all outputs reach their reset values before the next edge; after release, the first paddr is 0x80000000.

Source files
------------

// File: rtl/ysyx_25010008_prefetch_ifu.sv
// Credit-based instruction prefetch unit: issues in-order fetches, queues the
// responses and hands them to decode, with redirect flush and error halt.
module ysyx_25010008_prefetch_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CW       = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        pvalid,
  input  logic        pready,
  output logic [31:0] paddr,
  input  logic        rvalid,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic        rresp,
  output logic        ivalid,
  input  logic        iready,
  output logic [31:0] inst,
  output logic [31:0] ipc,
  output logic        ierr,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int          PW      = $clog2(DEPTH);
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic          run_q, run_d;
  logic          halt_q, halt_d;

  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_pc_q   [DEPTH];
  logic          mem_err_q  [DEPTH];

  logic [CW:0]   credit_s;
  logic          issue_s;
  logic          resp_acc_s;
  logic          push_s;
  logic          pop_s;
  logic [31:0]   redir_pc_s;
  logic          unused_s;

  // Queue plus outstanding requests must fit, so responses never need back-pressure.
  assign credit_s   = {1'b0, count_q} + {1'b0, out_cnt_q};
  assign pvalid     = run_q & ~halt_q & ~redirect & (credit_s < DEPTH_W);
  assign paddr      = fetch_pc_q;
  assign rready     = run_q;
  assign ivalid     = (count_q != {CW{1'b0}});
  assign inst       = mem_inst_q[rd_ptr_q];
  assign ipc        = mem_pc_q[rd_ptr_q];
  assign ierr       = mem_err_q[rd_ptr_q];

  assign issue_s    = pvalid & pready;
  assign resp_acc_s = rvalid & run_q & (out_cnt_q != {CW{1'b0}});
  assign push_s     = resp_acc_s & ~redirect & (drop_cnt_q == {CW{1'b0}}) & ~halt_q;
  assign pop_s      = ivalid & iready;
  assign redir_pc_s = {redirect_pc[31:2], 2'b00};
  assign unused_s   = ^redirect_pc[1:0];

  // Next-state logic; redirect overrides every other queue/PC update.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_cnt_d = drop_cnt_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    halt_d     = halt_q;
    run_d      = 1'b1;
    out_cnt_d  = out_cnt_q + CW'(issue_s) - CW'(resp_acc_s);
    if (redirect) begin
      fetch_pc_d = redir_pc_s;
      resp_pc_d  = redir_pc_s;
      halt_d     = 1'b0;
      drop_cnt_d = out_cnt_q - CW'(resp_acc_s);
      count_d    = {CW{1'b0}};
      rd_ptr_d   = {PW{1'b0}};
      wr_ptr_d   = {PW{1'b0}};
    end else begin
      fetch_pc_d = issue_s ? fetch_pc_q + 32'd4 : fetch_pc_q;
      if (resp_acc_s && (drop_cnt_q != {CW{1'b0}})) begin
        drop_cnt_d = drop_cnt_q - CW'(1'b1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
      if (push_s) begin
        resp_pc_d = resp_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + PW'(1'b1);
        halt_d    = halt_q | rresp;
      end else begin
        resp_pc_d = resp_pc_q;
        wr_ptr_d  = wr_ptr_q;
        halt_d    = halt_q;
      end
      rd_ptr_d = pop_s ? rd_ptr_q + PW'(1'b1) : rd_ptr_q;
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_cnt_q  <= {CW{1'b0}};
      drop_cnt_q <= {CW{1'b0}};
      count_q    <= {CW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      run_q      <= 1'b0;
      halt_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      run_q      <= run_d;
      halt_q     <= halt_d;
    end
  end

  // Instruction queue storage, cleared in reset so the outputs read zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_inst_q[i] <= 32'h0;
        mem_pc_q[i]   <= 32'h0;
        mem_err_q[i]  <= 1'b0;
      end
    end else if (push_s) begin
      mem_inst_q[wr_ptr_q] <= rdata;
      mem_pc_q[wr_ptr_q]   <= resp_pc_q;
      mem_err_q[wr_ptr_q]  <= rresp;
    end else begin
      mem_inst_q[wr_ptr_q] <= mem_inst_q[wr_ptr_q];
    end
  end

endmodule

// File: tb/tb_ysyx_25010008_prefetch_ifu.sv
// Self-checking bench: in-order memory model with epoch tags plus an
// expected-instruction scoreboard popped on every decode handshake.
module tb_ysyx_25010008_prefetch_ifu;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pvalid, rready, ivalid, ierr;
  logic        pready = 1'b1;
  logic        rvalid = 1'b0;
  logic        rresp = 1'b0;
  logic        iready = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] paddr, inst, ipc;
  logic [31:0] rdata = 32'h0;
  logic [31:0] redirect_pc = 32'h0;

  always #5 clk = ~clk;

  ysyx_25010008_prefetch_ifu #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst),
    .pvalid(pvalid), .pready(pready), .paddr(paddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .ivalid(ivalid), .iready(iready), .inst(inst), .ipc(ipc), .ierr(ierr),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic err; int epoch; int due; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; logic err; } ent_t;

  req_t        pending[$];
  ent_t        exp_q[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, epoch = 0, lat = 2, issued = 0, pready_mode = 0;
  logic        run_m = 1'b0, halt_m = 1'b0;
  logic [31:0] fetch_m = RESET_PC;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  logic [31:0] arm_pc = 32'h0;
  bit          data_mode = 0, iready_rand = 0, iready_cfg = 1, spurious = 0;
  bit          arm27 = 0, hit27 = 0, seen_err = 0, chk_first = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return data_mode ? {a[15:0], 16'h0013} : 32'h0000_0013;
  endfunction

  // One clock cycle: drive at negedge, check and update the model, then wait for posedge.
  task automatic cycle(input bit redir, input logic [31:0] rpc);
    req_t p;
    ent_t e;
    @(negedge clk);
    if (pending.size() != 0 && pending[0].due <= cyc) begin
      rvalid = 1'b1; rdata = pending[0].data; rresp = pending[0].err;
    end else if (spurious) begin
      rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 1'b1;
    end else begin
      rvalid = 1'b0; rdata = 32'h0; rresp = 1'b0;
    end
    iready      = iready_rand ? 1'($urandom_range(0, 1)) : iready_cfg;
    pready      = (pready_mode == 0) ? 1'b1 : (pready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    if (arm27 && rvalid && ivalid && iready && pending.size() != 0) begin
      redirect = 1'b1; redirect_pc = arm_pc; arm27 = 0; hit27 = 1;
      #1;
    end
    chk("rready", rready, run_m);
    chk("ivalid", ivalid, exp_q.size() != 0);
    chk("pvalid", pvalid, run_m && !halt_m && !redirect && (exp_q.size() + pending.size() < DEPTH));
    if (ivalid && iready) begin
      if (exp_q.size() == 0) begin
        chk("pop_empty", ivalid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("ipc_inst", {ipc, inst}, {e.pc, e.inst});
        chk("ierr", ierr, e.err);
        if (ierr) seen_err = 1;
        if (chk_first) begin
          chk("t25_first_ipc", ipc, 32'h8000_1000);
          chk_first = 0;
        end
      end
    end
    if (rvalid && rready && pending.size() != 0) begin
      p = pending.pop_front();
      if (!redirect && p.epoch == epoch && !halt_m) begin
        exp_q.push_back('{p.data, p.addr, p.err});
        if (p.err) halt_m = 1'b1;
      end
    end
    if (pvalid && pready) begin
      chk("paddr", paddr, fetch_m);
      chk("outstanding", pending.size() < DEPTH, 1'b1);
      pending.push_back('{fetch_m, data_of(fetch_m), fetch_m == err_addr, epoch, cyc + lat});
      fetch_m = fetch_m + 32'd4;
      issued++;
    end
    if (redirect) begin
      exp_q.delete();
      epoch++;
      halt_m  = 1'b0;
      fetch_m = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
  endtask

  // Asynchronous reset assertion between edges, with immediate output checks.
  task automatic do_reset(input int hold);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_pvalid", pvalid, 1'b0);
    chk("rst_rready", rready, 1'b0);
    chk("rst_ivalid", ivalid, 1'b0);
    chk("rst_paddr", paddr, RESET_PC);
    chk("rst_inst_ipc", {inst, ipc}, 64'h0);
    chk("rst_ierr", ierr, 1'b0);
    pending.delete();
    exp_q.delete();
    epoch++;
    halt_m = 1'b0; run_m = 1'b0; fetch_m = RESET_PC;
    rvalid = 1'b0; redirect = 1'b0;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_pvalid", pvalid, 1'b0);
    @(posedge clk);
    cyc++;
    run_m = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    pready_mode = 2; iready_rand = 0; iready_cfg = 1;
    while ((pending.size() != 0 || exp_q.size() != 0) && n < 60) begin
      cycle(0, 32'h0);
      n++;
    end
    chk("drain", pending.size() + exp_q.size(), 0);
  endtask

  initial begin
    int n;
    do_reset(2);

    // Steady streaming with a 2-cycle memory returning 0x13.
    data_mode = 0; lat = 2; iready_cfg = 1;
    repeat (40) cycle(0, 32'h0);

    // Decode stalled: credits fill, then one pop frees exactly one request.
    drain();
    pready_mode = 0; iready_cfg = 0; issued = 0;
    repeat (12) cycle(0, 32'h0);
    chk("t24_issued", issued, 4);
    #1;
    chk("t24_pvalid", pvalid, 1'b0);
    chk("t24_ivalid", ivalid, 1'b1);
    issued = 0; iready_cfg = 1;
    cycle(0, 32'h0);
    iready_cfg = 0;
    repeat (10) cycle(0, 32'h0);
    chk("t24_one_more", issued, 1);

    // Redirect with three requests in flight.
    iready_cfg = 1; data_mode = 1; lat = 3; n = 0;
    while (pending.size() != 3 && n < 40) begin
      cycle(0, 32'h0);
      n++;
    end
    chk("t25_wait", pending.size(), 3);
    chk_first = 1;
    cycle(1, 32'h8000_1003);
    iready_rand = 1; pready_mode = 1;
    repeat (40) cycle(0, 32'h0);
    chk("t25_first_seen", chk_first, 1'b0);

    // Reset mid-burst, then an access error on 0x80000008.
    iready_rand = 0; iready_cfg = 1; pready_mode = 0; lat = 2;
    repeat (5) cycle(0, 32'h0);
    err_addr = 32'h8000_0008;
    do_reset(1);
    repeat (25) cycle(0, 32'h0);
    chk("t26_ierr_seen", seen_err, 1'b1);
    spurious = 1;
    cycle(0, 32'h0);
    spurious = 0;
    err_addr = 32'hFFFF_FFFF;
    cycle(1, 32'h8000_2000);
    iready_rand = 1; pready_mode = 1;
    repeat (30) cycle(0, 32'h0);

    // Redirect coinciding with a response and a decode handshake.
    iready_rand = 0; iready_cfg = 1; pready_mode = 0; lat = 2;
    arm_pc = 32'h8000_3000; arm27 = 1; n = 0;
    while (!hit27 && n < 40) begin
      cycle(0, 32'h0);
      n++;
    end
    chk("t27_hit", hit27, 1'b1);
    #1;
    chk("t27_count0", ivalid, 1'b0);
    iready_rand = 1;
    repeat (30) cycle(0, 32'h0);

    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
